// File: rtl/alu_seq_pkg.sv
// Shared types and default timing constants for the ALU input sequencer.
// Optional idle-timeout feature is enabled by defining ALU_SEQ_TIMEOUT_EN.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_OP1    = 2'b00,
        S_OP2    = 2'b01,
        S_OPCODE = 2'b10,
        S_RESULT = 2'b11
    } seq_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 500_000_000;

    function automatic logic is_entry_state(input seq_state_t s);
        return (s == S_OP2) || (s == S_OPCODE);
    endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Synchronises a raw push-button, debounces both edges with a stability
// counter and emits a one-cycle pulse on each accepted press.
module btn_debouncer
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic RST_BTN_n,
    input  logic raw,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            cnt         <= '0;
            level       <= 1'b0;
            level_q     <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            // A sample agreeing with the accepted level means any pending change bounced back.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            level_q     <= level;
            press_pulse <= level & ~level_q;
        end
    end

endmodule

// File: rtl/alu_input_sequencer.sv
// Steps op1 -> op2 -> opcode -> result on debounced "next" presses, issuing load strobes.
// Optional idle timeout in S_OP2/S_OPCODE is compiled in with ALU_SEQ_TIMEOUT_EN.
module alu_input_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       RST_BTN_n,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic       ld_op1,
    output logic       ld_op2,
    output logic       ld_opcode,
    output logic [1:0] state_o,
    output logic       result_valid,
    output logic       timeout_o
);

    logic       rst_q1;
    logic       rst_n;
    logic       next_press;
    logic       clear_press;
    logic       next_level;
    logic       clear_level;
    logic       unused_levels;
    seq_state_t state;
    seq_state_t state_n;
    logic       ld_op1_n;
    logic       ld_op2_n;
    logic       ld_opcode_n;
    logic       timeout_n;
    logic       timeout_hit;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            rst_q1 <= 1'b0;
            rst_n  <= 1'b0;
        end else begin
            rst_q1 <= 1'b1;
            rst_n  <= rst_q1;
        end
    end

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk         (clk),
        .RST_BTN_n   (rst_n),
        .raw         (btn_next),
        .level       (next_level),
        .press_pulse (next_press)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk         (clk),
        .RST_BTN_n   (rst_n),
        .raw         (btn_clear),
        .level       (clear_level),
        .press_pulse (clear_press)
    );

    assign unused_levels = next_level ^ clear_level;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;

    assign timeout_hit = is_entry_state(state) && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!is_entry_state(state) || (state_n != state) || next_press || clear_press) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    // Strobes are single-cycle pulses with no back-pressure: the bank must capture on every strobe.
    always_comb begin
        state_n     = state;
        ld_op1_n    = 1'b0;
        ld_op2_n    = 1'b0;
        ld_opcode_n = 1'b0;
        timeout_n   = 1'b0;
        if (timeout_hit) begin
            state_n   = S_OP1;
            timeout_n = 1'b1;
        end else if (clear_press) begin
            state_n = S_OP1;
        end else if (next_press) begin
            case (state)
                S_OP1:    begin state_n = S_OP2;    ld_op1_n    = 1'b1; end
                S_OP2:    begin state_n = S_OPCODE; ld_op2_n    = 1'b1; end
                S_OPCODE: begin state_n = S_RESULT; ld_opcode_n = 1'b1; end
                default:  state_n = S_OP1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_OP1;
            ld_op1       <= 1'b0;
            ld_op2       <= 1'b0;
            ld_opcode    <= 1'b0;
            result_valid <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= state_n;
            ld_op1       <= ld_op1_n;
            ld_op2       <= ld_op2_n;
            ld_opcode    <= ld_opcode_n;
            result_valid <= (state_n == S_RESULT);
            timeout_o    <= timeout_n;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20).
// Expectations for the idle timeout follow ALU_SEQ_TIMEOUT_EN.
module tb_alu_input_sequencer;

    localparam int D = 4;
    localparam int T = 20;
`ifdef ALU_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       RST_BTN_n;
    logic       btn_next;
    logic       btn_clear;
    logic       ld_op1;
    logic       ld_op2;
    logic       ld_opcode;
    logic [1:0] state_o;
    logic       result_valid;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;
    int n_op1 = 0;
    int n_op2 = 0;
    int n_opc = 0;
    int n_to = 0;
    int n_multi = 0;
    int snap_a;
    int snap_b;
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];

    alu_input_sequencer #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .RST_BTN_n    (RST_BTN_n),
        .btn_next     (btn_next),
        .btn_clear    (btn_clear),
        .ld_op1       (ld_op1),
        .ld_op2       (ld_op2),
        .ld_opcode    (ld_opcode),
        .state_o      (state_o),
        .result_valid (result_valid),
        .timeout_o    (timeout_o)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // strobe monitor feeding the scoreboard
    always @(negedge clk) begin
        if (RST_BTN_n) begin
            if (ld_op1)    begin n_op1++; got_q.push_back(2'd1); end
            if (ld_op2)    begin n_op2++; got_q.push_back(2'd2); end
            if (ld_opcode) begin n_opc++; got_q.push_back(2'd3); end
            if ((int'(ld_op1) + int'(ld_op2) + int'(ld_opcode)) > 1) n_multi++;
            if (timeout_o) n_to++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 2ns after a rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        cyc(D + 4);
        btn_next = 1'b0;
        cyc(D + 4);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        cyc(D + 4);
        btn_clear = 1'b0;
        cyc(D + 4);
    endtask

    initial begin
        RST_BTN_n = 1'b0;
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        cyc(3);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_ld", 32'({ld_op1, ld_op2, ld_opcode}), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        RST_BTN_n = 1'b1;
        cyc(6);

        // 1: asynchronous reset while ld_op1 is high
        btn_next = 1'b1;
        cyc(D + 3);
        check("t1_pre_strobe", 32'(ld_op1), 32'd0);
        cyc(1);
        check("t1_strobe", 32'(ld_op1), 32'd1);
        check("t1_state_op2", 32'(state_o), 32'd1);
        #1 RST_BTN_n = 1'b0;
        #1;
        check("t1_async_state", 32'(state_o), 32'd0);
        check("t1_async_ld", 32'(ld_op1), 32'd0);
        check("t1_async_valid", 32'(result_valid), 32'd0);
        btn_next = 1'b0;
        cyc(3);
        RST_BTN_n = 1'b1;
        snap_a = n_op1 + n_op2 + n_opc;
        cyc(12);
        check("t1_release_state", 32'(state_o), 32'd0);
        check("t1_release_nostrobe", 32'(n_op1 + n_op2 + n_opc - snap_a), 32'd0);

        // 2: full entry sequence
        press_next();
        exp_q.push_back(2'd1);
        check("t2_state_op2", 32'(state_o), 32'd1);
        press_next();
        exp_q.push_back(2'd2);
        check("t2_state_opcode", 32'(state_o), 32'd2);
        check("t2_valid_low", 32'(result_valid), 32'd0);
        press_next();
        exp_q.push_back(2'd3);
        check("t2_state_result", 32'(state_o), 32'd3);
        check("t2_valid_high", 32'(result_valid), 32'd1);
        snap_a = n_op1 + n_op2 + n_opc;
        press_next();
        check("t2_wrap_state", 32'(state_o), 32'd0);
        check("t2_wrap_valid", 32'(result_valid), 32'd0);
        check("t2_wrap_nostrobe", 32'(n_op1 + n_op2 + n_opc - snap_a), 32'd0);

        // 3: bouncing press, then bouncing release
        snap_a = n_op1;
        for (int i = 0; i < 6; i++) begin
            btn_next = (i % 2 == 0);
            cyc(2);
        end
        check("t3_bounce_nostrobe", 32'(n_op1 - snap_a), 32'd0);
        btn_next = 1'b1;
        cyc(7);
        check("t3_pre_strobe", 32'(ld_op1), 32'd0);
        cyc(1);
        check("t3_strobe_at_8", 32'(ld_op1), 32'd1);
        exp_q.push_back(2'd1);
        cyc(1);
        check("t3_strobe_one_cycle", 32'(ld_op1), 32'd0);
        btn_next = 1'b0;
        cyc(2);
        btn_next = 1'b1;
        cyc(1);
        btn_next = 1'b0;
        cyc(6);
        check("t3_single_op1", 32'(n_op1 - snap_a), 32'd1);
        check("t3_state_op2", 32'(state_o), 32'd1);

        // 4: next and clear together in S_OPCODE
        press_next();
        exp_q.push_back(2'd2);
        check("t4_state_opcode", 32'(state_o), 32'd2);
        snap_a = n_opc;
        btn_next  = 1'b1;
        btn_clear = 1'b1;
        cyc(D + 4);
        check("t4_clear_wins_state", 32'(state_o), 32'd0);
        check("t4_no_ld_opcode", 32'(ld_opcode), 32'd0);
        btn_next  = 1'b0;
        btn_clear = 1'b0;
        cyc(D + 4);
        check("t4_opcode_count", 32'(n_opc - snap_a), 32'd0);
        check("t4_state_final", 32'(state_o), 32'd0);

        // 5: long hold from S_OP1
        snap_a = n_op1;
        snap_b = n_to;
        btn_next = 1'b1;
        cyc(D + 4);
        check("t5_strobe", 32'(ld_op1), 32'd1);
        exp_q.push_back(2'd1);
        for (int i = 1; i <= 100 - (D + 4) - 1; i++) begin
            cyc(1);
            check("t5_hold_state", 32'(state_o), (TO_EN && i >= T) ? 32'd0 : 32'd1);
        end
        btn_next = 1'b0;
        cyc(10);
        check("t5_single_op1", 32'(n_op1 - snap_a), 32'd1);
        check("t5_timeouts", 32'(n_to - snap_b), TO_EN ? 32'd1 : 32'd0);

        // 6: idle timeout in S_OP2
        press_clear();
        check("t6_cleared", 32'(state_o), 32'd0);
        snap_b = n_to;
        btn_next = 1'b1;
        cyc(D + 4);
        check("t6_strobe", 32'(ld_op1), 32'd1);
        check("t6_state_op2", 32'(state_o), 32'd1);
        exp_q.push_back(2'd1);
        btn_next = 1'b0;
        cyc(T - 1);
        check("t6_before_state", 32'(state_o), 32'd1);
        check("t6_before_pulse", 32'(timeout_o), 32'd0);
        cyc(1);
        check("t6_pulse", 32'(timeout_o), 32'(TO_EN));
        check("t6_state", 32'(state_o), TO_EN ? 32'd0 : 32'd1);
        check("t6_no_ld", 32'({ld_op1, ld_op2, ld_opcode}), 32'd0);
        cyc(1);
        check("t6_pulse_one_cycle", 32'(timeout_o), 32'd0);
        cyc(T);
        check("t6_timeout_count", 32'(n_to - snap_b), TO_EN ? 32'd1 : 32'd0);
        check("t6_final_state", 32'(state_o), TO_EN ? 32'd0 : 32'd1);

        // scoreboard and final report
        check("sb_multi_strobe", 32'(n_multi), 32'd0);
        check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("sb_order", 32'(got_q[i]), 32'(exp_q[i]));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
